// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store path: byte-addressed little-endian store,
// RISC-V sized accesses, configurable wait states, valid/ready request and response channels.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q;
  logic [7:0]            mem_q [Depth];
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            funct3_q;
  logic [3:0]            cnt_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;

  logic                  accept;
  logic                  commit;
  logic                  use_req;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [2:0]            cur_funct3;
  logic                  illegal;
  logic                  misal;
  logic                  acc_err;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlanes;
  logic [DATA_WIDTH-1:0] word_rd;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] resp_rdata_d;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH];

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access commits on the acceptance edge, straight from the inputs.
  assign use_req    = (state_q == StIdle);
  assign cur_we     = use_req ? req_we                     : we_q;
  assign cur_addr   = use_req ? req_addr[ADDR_WIDTH-1:0]   : addr_q;
  assign cur_wdata  = use_req ? req_wdata                  : wdata_q;
  assign cur_funct3 = use_req ? req_funct3                 : funct3_q;

  assign commit = (LATENCY == 0) ? accept
                                 : ((state_q == StBusy) && (cnt_q == 4'd0) && !rst);

  always_comb begin
    illegal = (cur_funct3[1:0] == 2'b11) || (cur_funct3[2] && (cur_we || cur_funct3[1]));
    misal   = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
              ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    acc_err = illegal || misal;
    unique case (cur_funct3[1:0])
      2'b00:   be = 4'b0001 << cur_addr[1:0];
      2'b01:   be = 4'b0011 << cur_addr[1:0];
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wlanes = cur_wdata << {cur_addr[1:0], 3'b000};
  end

  always_comb begin
    word_rd = '0;
    for (int i = 0; i < 4; i++) begin
      word_rd[8*i +: 8] = mem_q[{cur_addr[ADDR_WIDTH-1:2], 2'(i)}];
    end
    shifted = word_rd >> {cur_addr[1:0], 3'b000};
    case (cur_funct3)
      3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = '0;
    endcase
    resp_rdata_d = (cur_we || acc_err) ? '0 : load_data;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[{cur_addr[ADDR_WIDTH-1:2], 2'(i)}] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q     <= req_we;
            addr_q   <= req_addr[ADDR_WIDTH-1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            cnt_q    <= 4'(LATENCY - 1);
            state_q  <= (LATENCY == 0) ? StResp : StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (commit) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= acc_err;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=2 and LATENCY=0) checked every cycle
// against a byte-array transaction model, plus directed literal expectations.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_funct3(req_funct3[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_funct3(req_funct3[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  // Transaction-level model state, one slot per instance.
  logic [7:0]  mm [2][4096];
  bit          pend [2];
  bit          comm [2];
  int          due  [2];
  int          cyc = 0;
  bit          m_we [2];
  bit [31:0]   m_addr [2];
  bit [31:0]   m_wd [2];
  bit [2:0]    m_f [2];
  bit [31:0]   exp_rd [2];
  bit          exp_err [2];

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void m_access(input int k, input bit we, input bit [31:0] addr,
                                   input bit [31:0] wd, input bit [2:0] f,
                                   output bit err, output bit [31:0] rd);
    int n;
    bit sgn;
    int a;
    bit [31:0] v;
    a   = int'(addr[11:0]);
    n   = 0;
    sgn = 0;
    case (f)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: n = 0;
    endcase
    if (we && f > 3'd2) n = 0;
    if (n == 0) err = 1;
    else err = (a % n) != 0;
    rd = 0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[k][a+i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[k][a+i]) << (8*i));
        if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endfunction

  // Model: accept when idle, commit LATENCY edges later, finish on the response handshake.
  initial forever begin
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        pend[k] = 0;
      end else begin
        if (pend[k] && comm[k] && resp_ready[k]) begin
          pend[k] = 0;
        end else if (!pend[k] && req_valid[k]) begin
          m_we[k]   = req_we[k];
          m_addr[k] = req_addr[k];
          m_wd[k]   = req_wdata[k];
          m_f[k]    = req_funct3[k];
          pend[k]   = 1;
          comm[k]   = 0;
          due[k]    = cyc + lat_of(k);
        end
        if (pend[k] && !comm[k] && cyc == due[k]) begin
          m_access(k, m_we[k], m_addr[k], m_wd[k], m_f[k], exp_err[k], exp_rd[k]);
          comm[k] = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d req_ready", k), req_ready[k], !rst[k] && !pend[k]);
      chk($sformatf("k%0d resp_valid", k), resp_valid[k], pend[k] && comm[k]);
      if (pend[k] && comm[k]) begin
        chk($sformatf("k%0d model rdata", k), resp_rdata[k], exp_rd[k]);
        chk($sformatf("k%0d model err", k), resp_err[k], exp_err[k]);
      end
    end
  end

  task automatic wait_ready(int k);
    int n = 0;
    while (!req_ready[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[k]) chk($sformatf("k%0d ready timeout", k), req_ready[k], 1);
  endtask

  task automatic txn(int k, bit we, bit [31:0] a, bit [31:0] wd, bit [2:0] f,
                     bit [31:0] lit_rd, bit lit_err, int hold);
    int lat = 0;
    wait_ready(k);
    req_valid[k]  = 1;
    req_we[k]     = we;
    req_addr[k]   = a;
    req_wdata[k]  = wd;
    req_funct3[k] = f;
    resp_ready[k] = (hold == 0);
    @(posedge clk); #1;
    // A competing request while busy must be ignored.
    req_we[k]     = 1;
    req_addr[k]   = 32'h0000_0FF0;
    req_wdata[k]  = 32'h5555_5555;
    req_funct3[k] = 3'b010;
    while (!resp_valid[k] && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("k%0d latency @%h", k, a), lat, lat_of(k));
    chk($sformatf("k%0d rdata @%h f%0d", k, a, f), resp_rdata[k], lit_rd);
    chk($sformatf("k%0d err @%h f%0d", k, a, f), resp_err[k], lit_err);
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = h[0];
      @(posedge clk); #1;
    end
    if (hold > 0) chk($sformatf("k%0d held rdata @%h", k, a), resp_rdata[k], lit_rd);
    req_valid[k]  = 0;
    resp_ready[k] = 1;
    @(posedge clk); #1;
    chk($sformatf("k%0d ready after resp @%h", k, a), req_ready[k], 1);
  endtask

  task automatic rst_txn(int k, bit [31:0] a, bit [31:0] wd);
    wait_ready(k);
    req_valid[k]  = 1;
    req_we[k]     = 1;
    req_addr[k]   = a;
    req_wdata[k]  = wd;
    req_funct3[k] = 3'b010;
    resp_ready[k] = 0;
    @(posedge clk); #1;
    req_valid[k] = 0;
    chk($sformatf("k%0d valid after accept", k), resp_valid[k], lat_of(k) == 0);
    rst[k] = 1;
    @(posedge clk); #1;
    rst[k] = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("k%0d no resp after rst", k), resp_valid[k], 0);
      @(posedge clk); #1;
    end
    resp_ready[k] = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1; req_valid[k] = 0; req_we[k] = 0; req_addr[k] = 0;
      req_wdata[k] = 0; req_funct3[k] = 0; resp_ready[k] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d reset valid", k), resp_valid[k], 0);
      chk($sformatf("k%0d reset rdata", k), resp_rdata[k], 0);
      chk($sformatf("k%0d reset err", k), resp_err[k], 0);
      chk($sformatf("k%0d reset ready", k), req_ready[k], 0);
      rst[k] = 0;
    end
    @(posedge clk); #1;
    chk("k0 ready after release", req_ready[0], 1);

    // LATENCY=2 instance
    txn(0, 1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0);
    txn(0, 0, 32'h010, 32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
    txn(0, 0, 32'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 0, 0);
    txn(0, 0, 32'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 0, 0);
    txn(0, 1, 32'h021, 32'h0,        3'b000, 32'h0, 0, 0);
    txn(0, 1, 32'h020, 32'h000000F0, 3'b000, 32'h0, 0, 0);
    txn(0, 1, 32'h022, 32'h00008001, 3'b001, 32'h0, 0, 0);
    txn(0, 0, 32'h020, 32'h0,        3'b000, 32'hFFFFFFF0, 0, 0);
    txn(0, 0, 32'h020, 32'h0,        3'b100, 32'h000000F0, 0, 0);
    txn(0, 0, 32'h022, 32'h0,        3'b001, 32'hFFFF8001, 0, 0);
    txn(0, 0, 32'h022, 32'h0,        3'b101, 32'h00008001, 0, 0);
    txn(0, 0, 32'h020, 32'h0,        3'b010, 32'h800100F0, 0, 0);
    txn(0, 1, 32'h030, 32'h11223344, 3'b010, 32'h0, 0, 0);
    txn(0, 0, 32'h013, 32'h0,        3'b010, 32'h0, 1, 0);
    txn(0, 1, 32'h031, 32'h0000FFFF, 3'b001, 32'h0, 1, 0);
    txn(0, 0, 32'h030, 32'h0,        3'b010, 32'h11223344, 0, 0);
    txn(0, 0, 32'h030, 32'h0,        3'b011, 32'h0, 1, 0);
    txn(0, 1, 32'h030, 32'h000000AA, 3'b100, 32'h0, 1, 0);
    txn(0, 0, 32'h030, 32'h0,        3'b010, 32'h11223344, 0, 0);
    txn(0, 0, 32'h1010, 32'h0,       3'b010, 32'hDEADBEEF, 0, 5);
    txn(0, 1, 32'h040, 32'hCAFEF00D, 3'b010, 32'h0, 0, 0);
    rst_txn(0, 32'h040, 32'h12345678);
    txn(0, 0, 32'h040, 32'h0,        3'b010, 32'hCAFEF00D, 0, 0);

    // LATENCY=0 instance
    txn(1, 1, 32'h040, 32'hA5A5C3C3, 3'b010, 32'h0, 0, 0);
    txn(1, 0, 32'h042, 32'h0,        3'b101, 32'h0000A5A5, 0, 0);
    txn(1, 0, 32'h041, 32'h0,        3'b001, 32'h0, 1, 3);
    rst_txn(1, 32'h040, 32'h12345678);
    txn(1, 0, 32'h040, 32'h0,        3'b010, 32'h12345678, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
